// File: rtl/softex_pkg.sv
// Shared constants and types for the SoftEx TCDM lane splitter.
package softex_pkg;

  localparam int unsigned LANE_W             = 64;
  localparam int unsigned ROW_STRIDE_DEFAULT = 32;

  typedef enum logic {
    SPLIT_IDLE,
    SPLIT_PARTIAL
  } split_state_e;

endpackage

// File: rtl/softex_lane_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module softex_lane_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/softex_tcdm_lane_splitter.sv
// Splits one wide HCI request into MP 64-bit TCDM lane requests and re-merges
// the per-lane responses, buffering lanes that answer out of step.
module softex_tcdm_lane_splitter
  import softex_pkg::*;
#(
  parameter int unsigned MP         = 4,
  parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEFAULT,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IW         = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [31:0]                  add_i,
  input  logic                         wen_i,
  input  logic [MP*8-1:0]              be_i,
  input  logic [MP*LANE_W-1:0]         data_i,
  input  logic [IW-1:0]                id_i,
  output logic                         r_valid_o,
  input  logic                         r_ready_i,
  output logic [MP*LANE_W-1:0]         r_data_o,
  output logic [IW-1:0]                r_id_o,
  output logic [MP-1:0]                lane_req_o,
  input  logic [MP-1:0]                lane_gnt_i,
  output logic [MP-1:0][31:0]          lane_add_o,
  output logic [MP-1:0]                lane_wen_o,
  output logic [MP-1:0][7:0]           lane_be_o,
  output logic [MP-1:0][LANE_W-1:0]    lane_data_o,
  output logic [MP-1:0][IW-1:0]        lane_id_o,
  input  logic [MP-1:0]                lane_r_valid_i,
  output logic [MP-1:0]                lane_r_ready_o,
  input  logic [MP-1:0][LANE_W-1:0]    lane_r_data_i
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  split_state_e              state_q, state_d;
  logic [MP-1:0]             granted_q, granted_d;
  logic [CW-1:0]             outstanding_q;
  logic                      credit_ok, pop;
  logic [MP-1:0]             lane_push, lane_full, lane_empty;
  logic [MP-1:0][LANE_W-1:0] lane_head;
  logic                      id_full, id_empty;

  // Gating with rst_ni keeps the handshakes quiet while reset is held.
  assign credit_ok  = rst_ni & (outstanding_q < CW'(DEPTH));
  assign lane_req_o = {MP{req_i & credit_ok}} & ~granted_q;
  assign gnt_o      = req_i & credit_ok & (&(granted_q | lane_gnt_i));

  always_comb begin
    granted_d = gnt_o ? '0 : (granted_q | (lane_req_o & lane_gnt_i));
    state_d   = (granted_d == '0) ? SPLIT_IDLE : SPLIT_PARTIAL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SPLIT_IDLE;
      granted_q     <= '0;
      outstanding_q <= '0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      if (gnt_o && !pop)      outstanding_q <= outstanding_q + 1'b1;
      else if (!gnt_o && pop) outstanding_q <= outstanding_q - 1'b1;
    end
  end

  assign r_valid_o      = &(~lane_empty);
  assign pop            = r_valid_o & r_ready_i;
  assign r_data_o       = lane_head;
  assign lane_r_ready_o = ~lane_full;
  // Orphan responses (nothing outstanding) are dropped rather than buffered.
  assign lane_push      = lane_r_valid_i & lane_r_ready_o & {MP{outstanding_q != '0}};
  assign lane_wen_o     = {MP{wen_i}};

  for (genvar ii = 0; ii < MP; ii++) begin : g_lane
    assign lane_add_o[ii]  = add_i + 32'(ii * ROW_STRIDE);
    assign lane_be_o[ii]   = be_i[ii*8 +: 8];
    assign lane_data_o[ii] = data_i[ii*LANE_W +: LANE_W];
    assign lane_id_o[ii]   = id_i;

    softex_lane_fifo #(.WIDTH(LANE_W), .DEPTH(DEPTH)) i_lane_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (lane_push[ii]),
      .data_i  (lane_r_data_i[ii]),
      .pop_i   (pop),
      .data_o  (lane_head[ii]),
      .full_o  (lane_full[ii]),
      .empty_o (lane_empty[ii])
    );
  end

  softex_lane_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_o),
    .data_i  (id_i),
    .pop_i   (pop),
    .data_o  (r_id_o),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == SPLIT_PARTIAL) |-> req_i)
    else $error("request dropped while lanes partially granted");

  a_no_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|lane_r_valid_i) |-> (outstanding_q != '0))
    else $error("lane response with no outstanding transaction");

  a_id_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> (!id_full || pop))
    else $error("id fifo overflow");

  a_id_avail: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_valid_o |-> !id_empty)
    else $error("merged response without id");

endmodule

// File: tb/tb_softex_tcdm_lane_splitter.sv
// Randomised and directed bench for softex_tcdm_lane_splitter (MP=4, DEPTH=2).
module tb_softex_tcdm_lane_splitter;
  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_i, gnt_o, wen_i, r_valid_o, r_ready_i;
  logic [31:0]       add_i, be_i;
  logic [255:0]      data_i, r_data_o;
  logic [7:0]        id_i, r_id_o;
  logic [3:0]        lane_req_o, lane_gnt_i, lane_wen_o, lane_r_valid_i, lane_r_ready_o;
  logic [3:0][31:0]  lane_add_o;
  logic [3:0][7:0]   lane_be_o, lane_id_o;
  logic [3:0][63:0]  lane_data_o, lane_r_data_i;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  softex_tcdm_lane_splitter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .lane_req_o(lane_req_o), .lane_gnt_i(lane_gnt_i), .lane_add_o(lane_add_o),
    .lane_wen_o(lane_wen_o), .lane_be_o(lane_be_o), .lane_data_o(lane_data_o),
    .lane_id_o(lane_id_o), .lane_r_valid_i(lane_r_valid_i),
    .lane_r_ready_o(lane_r_ready_o), .lane_r_data_i(lane_r_data_i)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue_full(input logic [31:0] a, input logic [7:0] id);
    req_i = 1'b1; add_i = a; id_i = id; wen_i = 1'b1; lane_gnt_i = 4'hF;
    settle();
    nvec++;
    if (gnt_o !== 1'b1 || lane_req_o !== 4'hF) begin
      nerr++;
      $display("FAIL issue_full id=%h: gnt_o=%b lane_req_o=%b, want 1 / 1111", id, gnt_o, lane_req_o);
    end
    step();
    req_i = 1'b0; lane_gnt_i = 4'h0;
  endtask

  task automatic respond(input logic [3:0] mask, input logic [255:0] d);
    lane_r_valid_i = mask; lane_r_data_i = d;
    step();
    lane_r_valid_i = 4'h0;
  endtask

  task automatic pop_check(input logic [255:0] d, input logic [7:0] id);
    r_ready_i = 1'b1;
    settle();
    nvec++;
    if (r_valid_o !== 1'b1 || r_data_o !== d || r_id_o !== id) begin
      nerr++;
      $display("FAIL pop id=%h: r_valid=%b r_id=%h r_data=%h, want 1 %h %h", id, r_valid_o, r_id_o, r_data_o, id, d);
    end
    step();
    r_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b1; lane_gnt_i = 4'hF; r_ready_i = 1'b1;
    settle();
    nvec++;
    if (gnt_o !== 1'b0 || r_valid_o !== 1'b0 || lane_req_o !== 4'h0 || lane_r_ready_o !== 4'hF) begin
      nerr++;
      $display("FAIL reset_outputs: gnt=%b r_valid=%b lane_req=%b lane_r_ready=%b, want 0 0 0000 1111",
               gnt_o, r_valid_o, lane_req_o, lane_r_ready_o);
    end
    step(); step();
    req_i = 1'b0; lane_gnt_i = 4'h0; r_ready_i = 1'b0;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_addr_payload();
    logic [31:0] addrs [6];
    logic [31:0] e;
    addrs[0] = 32'h0000_1000; addrs[1] = 32'hFFFF_FFF0; addrs[2] = 32'hFFFF_FFE0;
    addrs[3] = $urandom; addrs[4] = $urandom; addrs[5] = 32'h0;
    for (int v = 0; v < 6; v++) begin
      add_i = addrs[v]; be_i = $urandom; data_i = rnd256(); id_i = 8'($urandom); wen_i = 1'($urandom);
      settle();
      for (int l = 0; l < 4; l++) begin
        e = addrs[v] + 32'(l * 32);
        nvec++;
        if (lane_add_o[l] !== e || lane_be_o[l] !== be_i[l*8 +: 8] || lane_data_o[l] !== data_i[l*64 +: 64]
            || lane_id_o[l] !== id_i || lane_wen_o[l] !== wen_i) begin
          nerr++;
          $display("FAIL lane_payload v%0d lane%0d: add=%h be=%h id=%h wen=%b, want add=%h be=%h id=%h wen=%b",
                   v, l, lane_add_o[l], lane_be_o[l], lane_id_o[l], lane_wen_o[l], e, be_i[l*8 +: 8], id_i, wen_i);
        end
      end
    end
    step();
  endtask

  task automatic test_full_grant();
    logic [255:0] d;
    d = rnd256();
    issue_full(32'h0000_1000, 8'h5A);
    lane_r_valid_i = 4'hF; lane_r_data_i = d;
    settle();
    nvec++;
    if (r_valid_o !== 1'b0) begin
      nerr++; $display("FAIL full_grant_early_valid: r_valid=%b, want 0", r_valid_o);
    end
    step();
    lane_r_valid_i = 4'h0;
    pop_check(d, 8'h5A);
    settle();
    nvec++;
    if (r_valid_o !== 1'b0) begin
      nerr++; $display("FAIL full_grant_after_pop: r_valid=%b, want 0", r_valid_o);
    end
  endtask

  task automatic test_staggered();
    logic [3:0] gnts [3];
    logic [3:0] ereq [3];
    logic       egnt [3];
    logic [255:0] d;
    gnts[0] = 4'b0101; ereq[0] = 4'b1111; egnt[0] = 1'b0;
    gnts[1] = 4'b0101; ereq[1] = 4'b1010; egnt[1] = 1'b0;
    gnts[2] = 4'b1010; ereq[2] = 4'b1010; egnt[2] = 1'b1;
    req_i = 1'b1; add_i = 32'h0000_2000; id_i = 8'h77;
    for (int c = 0; c < 3; c++) begin
      lane_gnt_i = gnts[c];
      settle();
      nvec++;
      if (lane_req_o !== ereq[c] || gnt_o !== egnt[c]) begin
        nerr++;
        $display("FAIL staggered c%0d: lane_req=%b gnt=%b, want %b %b", c, lane_req_o, gnt_o, ereq[c], egnt[c]);
      end
      step();
    end
    req_i = 1'b0; lane_gnt_i = 4'h0;
    settle();
    nvec++;
    if (lane_req_o !== 4'h0 || gnt_o !== 1'b0) begin
      nerr++; $display("FAIL staggered_done: lane_req=%b gnt=%b, want 0000 0", lane_req_o, gnt_o);
    end
    d = rnd256();
    step();
    respond(4'hF, d);
    pop_check(d, 8'h77);
  endtask

  task automatic test_credit();
    logic [255:0] da, db, dc;
    da = rnd256(); db = rnd256(); dc = rnd256();
    r_ready_i = 1'b0;
    issue_full(32'h0000_3000, 8'hA1);
    issue_full(32'h0000_4000, 8'hA2);
    req_i = 1'b1; add_i = 32'h0000_5000; id_i = 8'hA3; lane_gnt_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      lane_r_valid_i = (c == 0) ? 4'hF : (c == 1) ? 4'hF : 4'h0;
      lane_r_data_i  = (c == 0) ? da : db;
      settle();
      nvec++;
      if (lane_req_o !== 4'h0 || gnt_o !== 1'b0) begin
        nerr++; $display("FAIL credit_block c%0d: lane_req=%b gnt=%b, want 0000 0", c, lane_req_o, gnt_o);
      end
      step();
    end
    lane_r_valid_i = 4'h0;
    r_ready_i = 1'b1;
    settle();
    nvec++;
    if (lane_req_o !== 4'h0 || gnt_o !== 1'b0 || r_valid_o !== 1'b1 || r_id_o !== 8'hA1 || r_data_o !== da) begin
      nerr++;
      $display("FAIL credit_pop_cycle: lane_req=%b gnt=%b r_valid=%b r_id=%h, want 0000 0 1 a1",
               lane_req_o, gnt_o, r_valid_o, r_id_o);
    end
    step();
    r_ready_i = 1'b0;
    settle();
    nvec++;
    if (lane_req_o !== 4'hF || gnt_o !== 1'b1) begin
      nerr++; $display("FAIL credit_restored: lane_req=%b gnt=%b, want 1111 1", lane_req_o, gnt_o);
    end
    step();
    req_i = 1'b0; lane_gnt_i = 4'h0;
    respond(4'hF, dc);
    pop_check(db, 8'hA2);
    pop_check(dc, 8'hA3);
  endtask

  task automatic test_slow_lane();
    logic [255:0] d;
    d = rnd256();
    issue_full(32'h0000_6000, 8'h3C);
    respond(4'b0111, d);
    r_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      nvec++;
      if (r_valid_o !== 1'b0) begin
        nerr++; $display("FAIL slow_lane_wait c%0d: r_valid=%b, want 0", c, r_valid_o);
      end
      step();
    end
    r_ready_i = 1'b0;
    respond(4'b1000, d);
    pop_check(d, 8'h3C);
  endtask

  task automatic test_reset_mid();
    logic [255:0] d1, d2;
    d1 = rnd256(); d2 = rnd256();
    issue_full(32'h0000_7000, 8'h11);
    respond(4'b0001, d1);
    req_i = 1'b1; add_i = 32'h0000_8000; id_i = 8'h22; lane_gnt_i = 4'b0011;
    step();
    lane_gnt_i = 4'h0;
    settle();
    nvec++;
    if (lane_req_o !== 4'b1100 || gnt_o !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_partial: lane_req=%b gnt=%b, want 1100 0", lane_req_o, gnt_o);
    end
    rst_ni = 1'b0;
    #1;
    req_i = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    r_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      nvec++;
      if (r_valid_o !== 1'b0 || lane_req_o !== 4'h0 || lane_r_ready_o !== 4'hF) begin
        nerr++;
        $display("FAIL reset_mid_after c%0d: r_valid=%b lane_req=%b lane_r_ready=%b, want 0 0000 1111",
                 c, r_valid_o, lane_req_o, lane_r_ready_o);
      end
      step();
    end
    r_ready_i = 1'b0;
    issue_full(32'h0000_9000, 8'h33);
    issue_full(32'h0000_A000, 8'h44);
    req_i = 1'b1; lane_gnt_i = 4'hF;
    settle();
    nvec++;
    if (gnt_o !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_credit: gnt=%b, want 0", gnt_o);
    end
    step();
    req_i = 1'b0; lane_gnt_i = 4'h0;
    respond(4'hF, d1);
    respond(4'hF, d2);
    pop_check(d1, 8'h33);
    pop_check(d2, 8'h44);
  endtask

  // Reference model: outstanding = entries in exp_id_q; a lane accepts while
  // it holds fewer than two buffered beats; merge when every lane holds one.
  logic [63:0]  pend_q [4][$];
  logic [255:0] exp_data_q [$];
  logic [7:0]   exp_id_q [$];

  task automatic test_random(input int n_txn);
    logic [3:0]   gmask, ereq, accept;
    logic         egnt, erv, popm;
    int           lane_cnt [4];
    int           issued, popped, cycles;
    logic [255:0] full;
    logic [63:0]  dl;
    gmask = '0; issued = 0; popped = 0; cycles = 0;
    for (int l = 0; l < 4; l++) lane_cnt[l] = 0;
    while (popped < n_txn && cycles < 20000) begin
      cycles++;
      if (!req_i && issued < n_txn && $urandom_range(0, 3) != 0) begin
        req_i = 1'b1; add_i = $urandom; id_i = 8'($urandom); be_i = $urandom;
        data_i = rnd256(); wen_i = 1'($urandom);
      end
      lane_gnt_i = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        lane_r_valid_i[l] = (pend_q[l].size() > 0 && lane_cnt[l] < 2 && $urandom_range(0, 2) != 0);
        lane_r_data_i[l]  = (pend_q[l].size() > 0) ? pend_q[l][0] : 64'h0;
      end
      r_ready_i = ($urandom_range(0, 3) != 0);
      settle();
      egnt = req_i && (exp_id_q.size() < 2) && (&(gmask | lane_gnt_i));
      ereq = (req_i && exp_id_q.size() < 2) ? ~gmask : 4'h0;
      erv  = (lane_cnt[0] > 0) && (lane_cnt[1] > 0) && (lane_cnt[2] > 0) && (lane_cnt[3] > 0);
      nvec++;
      if (lane_req_o !== ereq || gnt_o !== egnt || r_valid_o !== erv) begin
        nerr++;
        $display("FAIL random_hs cyc%0d: lane_req=%b gnt=%b r_valid=%b, want %b %b %b",
                 cycles, lane_req_o, gnt_o, r_valid_o, ereq, egnt, erv);
      end
      if (egnt) begin
        nvec++;
        for (int l = 0; l < 4; l++)
          if (lane_add_o[l] !== add_i + 32'(l * 32)) begin
            nerr++;
            $display("FAIL random_addr lane%0d: %h, want %h", l, lane_add_o[l], add_i + 32'(l * 32));
          end
      end
      popm = erv && r_ready_i;
      if (popm) begin
        nvec++;
        if (r_data_o !== exp_data_q[0] || r_id_o !== exp_id_q[0]) begin
          nerr++;
          $display("FAIL random_resp #%0d: id=%h data=%h, want id=%h data=%h",
                   popped, r_id_o, r_data_o, exp_id_q[0], exp_data_q[0]);
        end
      end
      accept = lane_r_valid_i;
      step();
      if (popm) begin
        void'(exp_data_q.pop_front()); void'(exp_id_q.pop_front());
        popped++;
        for (int l = 0; l < 4; l++) lane_cnt[l]--;
      end
      for (int l = 0; l < 4; l++)
        if (accept[l]) begin
          void'(pend_q[l].pop_front());
          lane_cnt[l]++;
        end
      if (egnt) begin
        for (int l = 0; l < 4; l++) begin
          dl = {$urandom, $urandom};
          pend_q[l].push_back(dl);
          full[l*64 +: 64] = dl;
        end
        exp_data_q.push_back(full);
        exp_id_q.push_back(id_i);
        issued++;
        gmask = '0;
        req_i = 1'b0;
      end else begin
        gmask = gmask | (ereq & lane_gnt_i);
      end
    end
    lane_r_valid_i = 4'h0; lane_gnt_i = 4'h0; r_ready_i = 1'b0;
    nvec++;
    if (popped != n_txn) begin
      nerr++; $display("FAIL random_timeout: %0d responses merged, want %0d", popped, n_txn);
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b1; be_i = '1; data_i = '0; id_i = '0;
    r_ready_i = 1'b0; lane_gnt_i = '0; lane_r_valid_i = '0; lane_r_data_i = '0;
    #3;
    test_reset();
    test_addr_payload();
    test_full_grant();
    test_staggered();
    test_credit();
    test_slow_lane();
    test_reset_mid();
    test_random(150);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
